// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared state encoding, default sizes and drain-latency formula for the TPU run sequencer
package tpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WSEL,
    S_RELOAD,
    S_FEED,
    S_DRAIN,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam int MATRIX_SIZE_DEF      = 64;
  localparam int ADDRESSSIZE_DEF      = 10;
  localparam int ADDRESSSIZE_FIFO_DEF = 2;
  localparam int RELOAD_CYCLES_DEF    = 2;

  // Array depth plus input skew plus output deskew: 2*M + 2 (130 for a 64x64 array).
  function automatic int drain_cycles(input int matrix_size);
    return 2 * matrix_size + 2;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tpu_run_sequencer_if.sv
// rtl/tpu_run_sequencer_if.sv - start/busy/done handshake plus datapath strobes of the run sequencer
interface tpu_run_sequencer_if
  import tpu_pkg::*;
#(
  parameter int ADDRESSSIZE      = ADDRESSSIZE_DEF,
  parameter int ADDRESSSIZE_fifo = ADDRESSSIZE_FIFO_DEF
);
  logic                        start;
  logic [ADDRESSSIZE-1:0]      ub_base;
  logic [ADDRESSSIZE-1:0]      res_base;
  logic [ADDRESSSIZE_fifo-1:0] weight_sel;
  logic                        busy;
  logic                        done;
  logic [ADDRESSSIZE-1:0]      ub_addr;
  logic                        feed_valid;
  logic [ADDRESSSIZE_fifo-1:0] wfifo_addr;
  logic                        we_rl;
  logic                        res_we;
  logic [ADDRESSSIZE-1:0]      res_addr;

  modport master (
    output start, ub_base, res_base, weight_sel,
    input  busy, done, ub_addr, feed_valid, wfifo_addr, we_rl, res_we, res_addr
  );

  modport slave (
    input  start, ub_base, res_base, weight_sel,
    output busy, done, ub_addr, feed_valid, wfifo_addr, we_rl, res_we, res_addr
  );
endinterface

// File: rtl/tpu_phase_counter.sv
// rtl/tpu_phase_counter.sv - loadable down-counter with terminal-count flag, shared by all timed phases
module tpu_phase_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_tc
);
  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_tc = (r_count == '0);
endmodule

// File: rtl/tpu_run_sequencer.sv
// rtl/tpu_run_sequencer.sv - one matrix pass: weight select/reload, row feed, drain, result capture
module tpu_run_sequencer
  import tpu_pkg::*;
#(
  parameter int MATRIX_SIZE      = MATRIX_SIZE_DEF,
  parameter int ADDRESSSIZE      = ADDRESSSIZE_DEF,
  parameter int ADDRESSSIZE_fifo = ADDRESSSIZE_FIFO_DEF,
  parameter int RELOAD_CYCLES    = RELOAD_CYCLES_DEF,
  parameter int DRAIN_CYCLES     = drain_cycles(MATRIX_SIZE)
) (
  input logic                clk,
  input logic                rstn,
  tpu_run_sequencer_if.slave bus
);
  localparam int CNT_MAX = max_int(max_int(MATRIX_SIZE, RELOAD_CYCLES), DRAIN_CYCLES);
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  // Phase lengths are loaded as N-1 so terminal count marks the phase's last cycle.
  localparam logic [CW-1:0] C_RELOAD = CW'(RELOAD_CYCLES - 1);
  localparam logic [CW-1:0] C_ROWS   = CW'(MATRIX_SIZE - 1);
  localparam logic [CW-1:0] C_DRAIN  = CW'(DRAIN_CYCLES - 1);

  if (MATRIX_SIZE < 1) begin : g_bad_matrix
    $error("tpu_run_sequencer: MATRIX_SIZE must be >= 1");
  end
  if (RELOAD_CYCLES < 1) begin : g_bad_reload
    $error("tpu_run_sequencer: RELOAD_CYCLES must be >= 1");
  end
  if (DRAIN_CYCLES < 1) begin : g_bad_drain
    $error("tpu_run_sequencer: DRAIN_CYCLES must be >= 1");
  end

  state_t                      r_state;
  logic [ADDRESSSIZE-1:0]      r_ub_base;
  logic [ADDRESSSIZE-1:0]      r_res_base;
  logic [ADDRESSSIZE-1:0]      r_ub_addr;
  logic [ADDRESSSIZE-1:0]      r_res_addr;
  logic [ADDRESSSIZE_fifo-1:0] r_wfifo_addr;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_we_rl;
  logic                        r_feed_valid;
  logic                        r_res_we;

  logic                        w_cnt_load;
  logic                        w_cnt_en;
  logic [CW-1:0]               w_cnt_val;
  logic                        w_tc;

  tpu_phase_counter #(.WIDTH(CW)) u_phase_counter (
    .clk        (clk),
    .rstn       (rstn),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_en       (w_cnt_en),
    .o_tc       (w_tc)
  );

  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_en   = 1'b0;
    w_cnt_val  = '0;
    case (r_state)
      S_WSEL: begin
        w_cnt_load = 1'b1;
        w_cnt_val  = C_RELOAD;
      end
      S_RELOAD: begin
        w_cnt_load = w_tc;
        w_cnt_en   = !w_tc;
        w_cnt_val  = C_ROWS;
      end
      S_FEED: begin
        w_cnt_load = w_tc;
        w_cnt_en   = !w_tc;
        w_cnt_val  = C_DRAIN;
      end
      S_DRAIN: begin
        w_cnt_load = w_tc;
        w_cnt_en   = !w_tc;
        w_cnt_val  = C_ROWS;
      end
      S_CAPTURE: w_cnt_en = 1'b1;
      default: ;
    endcase
  end

  // Outputs are written on the edge that enters each state, so they line up with r_state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_ub_base    <= '0;
      r_res_base   <= '0;
      r_ub_addr    <= '0;
      r_res_addr   <= '0;
      r_wfifo_addr <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_we_rl      <= 1'b0;
      r_feed_valid <= 1'b0;
      r_res_we     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_ub_base    <= bus.ub_base;
            r_res_base   <= bus.res_base;
            r_wfifo_addr <= bus.weight_sel;
            r_busy       <= 1'b1;
            r_state      <= S_WSEL;
          end
        end
        S_WSEL: begin
          r_we_rl <= 1'b1;
          r_state <= S_RELOAD;
        end
        S_RELOAD: begin
          if (w_tc) begin
            r_we_rl      <= 1'b0;
            r_feed_valid <= 1'b1;
            r_ub_addr    <= r_ub_base;
            r_state      <= S_FEED;
          end
        end
        S_FEED: begin
          if (w_tc) begin
            r_feed_valid <= 1'b0;
            r_state      <= S_DRAIN;
          end else begin
            r_ub_addr <= r_ub_addr + ADDRESSSIZE'(1);
          end
        end
        S_DRAIN: begin
          if (w_tc) begin
            r_res_we   <= 1'b1;
            r_res_addr <= r_res_base;
            r_state    <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (w_tc) begin
            r_res_we <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_res_addr <= r_res_addr + ADDRESSSIZE'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.ub_addr    = r_ub_addr;
  assign bus.feed_valid = r_feed_valid;
  assign bus.wfifo_addr = r_wfifo_addr;
  assign bus.we_rl      = r_we_rl;
  assign bus.res_we     = r_res_we;
  assign bus.res_addr   = r_res_addr;
endmodule

// File: tb/tb_tpu_run_sequencer.sv
// tb/tb_tpu_run_sequencer.sv - directed bench: small 4-row sequencer plus a default-parameter instance
module tb_tpu_run_sequencer;
  import tpu_pkg::*;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_bad;

  tpu_run_sequencer_if #(.ADDRESSSIZE(10), .ADDRESSSIZE_fifo(2)) bus ();
  tpu_run_sequencer_if #(.ADDRESSSIZE(10), .ADDRESSSIZE_fifo(2)) bus_d ();

  tpu_run_sequencer #(
    .MATRIX_SIZE(4), .ADDRESSSIZE(10), .ADDRESSSIZE_fifo(2),
    .RELOAD_CYCLES(2), .DRAIN_CYCLES(10)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  tpu_run_sequencer dut_d (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bit n of each mask is the output value seen at edge T0+n.
  logic [63:0] m_we, m_fv, m_rwe, m_done, m_busy, m_excl;
  logic [9:0]  c_ub   [0:63];
  logic [9:0]  c_ra   [0:63];
  logic [1:0]  c_wf   [0:63];
  logic        c_zero [0:63];
  logic        c_idle [0:63];

  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] v;
    v = '0;
    for (int i = lo; i <= hi; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic capture(input int ncyc, input int hold_until, input int pulse_a,
                         input int pulse_b, input int rst_at);
    m_we = '0; m_fv = '0; m_rwe = '0; m_done = '0; m_busy = '0; m_excl = '0;
    @(negedge clk);
    bus.start = 1'b1;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      m_we[n]   = bus.we_rl;
      m_fv[n]   = bus.feed_valid;
      m_rwe[n]  = bus.res_we;
      m_done[n] = bus.done;
      m_busy[n] = bus.busy;
      m_excl[n] = (bus.we_rl & bus.feed_valid) | (bus.we_rl & bus.res_we) | (bus.feed_valid & bus.res_we);
      c_ub[n]   = bus.ub_addr;
      c_ra[n]   = bus.res_addr;
      c_wf[n]   = bus.wfifo_addr;
      c_zero[n] = ({bus.busy, bus.done, bus.we_rl, bus.feed_valid, bus.res_we} == 5'b0) &&
                  (bus.ub_addr == 10'd0) && (bus.res_addr == 10'd0) && (bus.wfifo_addr == 2'd0);
      c_idle[n] = (dut.r_state == S_IDLE);
      if (n == 1) begin
        bus.ub_base    = 10'h155;
        bus.res_base   = 10'h2AA;
        bus.weight_sel = ~bus.weight_sel;
      end
      bus.start = (n <= hold_until) || (n == pulse_a) || (n == pulse_b);
      rstn      = (n != rst_at);
    end
    bus.start = 1'b0;
    rstn      = 1'b1;
  endtask

  task automatic wait_idle();
    int  k;
    k = 0;
    while ((bus.busy || bus.done) && k < 500) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (bus.busy || bus.done) begin
      n_bad++;
      $display("FAIL wait_idle: busy=%0b done=%0b after %0d cycles, required idle", bus.busy, bus.done, k);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.start = 1'b0; bus.ub_base = '0; bus.res_base = '0; bus.weight_sel = '0;
    bus_d.start = 1'b0; bus_d.ub_base = '0; bus_d.res_base = '0; bus_d.weight_sel = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done, bus.we_rl, bus.feed_valid, bus.res_we, bus.ub_addr, bus.res_addr, bus.wfifo_addr} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b we=%b fv=%b rwe=%b ub=%0d ra=%0d wf=%0d, required all 0",
               bus.busy, bus.done, bus.we_rl, bus.feed_valid, bus.res_we, bus.ub_addr, bus.res_addr, bus.wfifo_addr);
    end
    n_cmp++;
    if (dut.r_state !== S_IDLE) begin
      n_bad++;
      $display("FAIL reset_state: got %0d, required IDLE", dut.r_state);
    end
    n_cmp++;
    if ({bus_d.busy, bus_d.done, bus_d.res_we, bus_d.feed_valid, bus_d.we_rl} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_default_dut: got strobes %b, required 00000",
               {bus_d.busy, bus_d.done, bus_d.res_we, bus_d.feed_valid, bus_d.we_rl});
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    wait_idle();
    bus.ub_base = 10'd8; bus.res_base = 10'd20; bus.weight_sel = 2'd2;
    capture(25, 0, -1, -1, -1);
    n_cmp++;
    if (c_wf[1] !== 2'd2) begin n_bad++; $display("FAIL basic_wsel: got %0d, required 2", c_wf[1]); end
    n_cmp++;
    if (m_we !== span(2, 3)) begin n_bad++; $display("FAIL basic_we_rl: got %h, required %h", m_we, span(2, 3)); end
    n_cmp++;
    if (m_fv !== span(4, 7)) begin n_bad++; $display("FAIL basic_feed_valid: got %h, required %h", m_fv, span(4, 7)); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (c_ub[4+k] !== 10'(8 + k)) begin
        n_bad++; $display("FAIL basic_ub_addr[%0d]: got %0d, required %0d", k, c_ub[4+k], 8 + k);
      end
    end
    n_cmp++;
    if (c_ub[12] !== 10'd11) begin n_bad++; $display("FAIL basic_ub_hold: got %0d, required 11", c_ub[12]); end
    n_cmp++;
    if (m_rwe !== span(18, 21)) begin n_bad++; $display("FAIL basic_res_we: got %h, required %h", m_rwe, span(18, 21)); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (c_ra[18+k] !== 10'(20 + k)) begin
        n_bad++; $display("FAIL basic_res_addr[%0d]: got %0d, required %0d", k, c_ra[18+k], 20 + k);
      end
    end
    n_cmp++;
    if (m_done !== span(22, 22)) begin n_bad++; $display("FAIL basic_done: got %h, required %h", m_done, span(22, 22)); end
    n_cmp++;
    if (m_busy !== span(1, 21)) begin n_bad++; $display("FAIL basic_busy: got %h, required %h", m_busy, span(1, 21)); end
    n_cmp++;
    if (m_excl !== 64'd0) begin n_bad++; $display("FAIL basic_exclusive: got %h, required 0", m_excl); end
    n_cmp++;
    if (c_wf[25] !== 2'd2) begin n_bad++; $display("FAIL basic_wfifo_hold: got %0d, required 2", c_wf[25]); end
  endtask

  task automatic test_wrap();
    logic [9:0] exp_ub [0:3];
    logic [9:0] exp_ra [0:3];
    exp_ub = '{10'd1022, 10'd1023, 10'd0, 10'd1};
    exp_ra = '{10'd1023, 10'd0, 10'd1, 10'd2};
    wait_idle();
    bus.ub_base = 10'd1022; bus.res_base = 10'd1023; bus.weight_sel = 2'd1;
    capture(25, 0, -1, -1, -1);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (c_ub[4+k] !== exp_ub[k]) begin
        n_bad++; $display("FAIL wrap_ub_addr[%0d]: got %0d, required %0d", k, c_ub[4+k], exp_ub[k]);
      end
      n_cmp++;
      if (c_ra[18+k] !== exp_ra[k]) begin
        n_bad++; $display("FAIL wrap_res_addr[%0d]: got %0d, required %0d", k, c_ra[18+k], exp_ra[k]);
      end
    end
    n_cmp++;
    if (c_wf[2] !== 2'd1) begin n_bad++; $display("FAIL wrap_wsel: got %0d, required 1", c_wf[2]); end
  endtask

  task automatic test_start_ignored();
    wait_idle();
    bus.ub_base = 10'd0; bus.res_base = 10'd0; bus.weight_sel = 2'd3;
    capture(30, 0, 5, 19, -1);
    n_cmp++;
    if (m_done !== span(22, 22)) begin n_bad++; $display("FAIL ignore_done: got %h, required %h", m_done, span(22, 22)); end
    n_cmp++;
    if (m_busy !== span(1, 21)) begin n_bad++; $display("FAIL ignore_busy: got %h, required %h", m_busy, span(1, 21)); end
    n_cmp++;
    if (m_rwe !== span(18, 21)) begin n_bad++; $display("FAIL ignore_res_we: got %h, required %h", m_rwe, span(18, 21)); end
  endtask

  task automatic test_back_to_back();
    wait_idle();
    bus.ub_base = 10'd4; bus.res_base = 10'd40; bus.weight_sel = 2'd0;
    capture(50, 40, -1, -1, -1);
    n_cmp++;
    if (m_done !== (span(22, 22) | span(45, 45))) begin
      n_bad++; $display("FAIL b2b_done: got %h, required %h", m_done, span(22, 22) | span(45, 45));
    end
    n_cmp++;
    if (m_busy !== (span(1, 21) | span(24, 44))) begin
      n_bad++; $display("FAIL b2b_busy: got %h, required %h", m_busy, span(1, 21) | span(24, 44));
    end
    n_cmp++;
    if (c_idle[23] !== 1'b1) begin n_bad++; $display("FAIL b2b_idle_gap: got %b, required 1", c_idle[23]); end
    n_cmp++;
    if (m_we !== (span(2, 3) | span(25, 26))) begin
      n_bad++; $display("FAIL b2b_we_rl: got %h, required %h", m_we, span(2, 3) | span(25, 26));
    end
  endtask

  task automatic test_reset_mid_pass();
    wait_idle();
    bus.ub_base = 10'd8; bus.res_base = 10'd20; bus.weight_sel = 2'd2;
    capture(30, 0, -1, -1, 12);
    n_cmp++;
    if (c_zero[13] !== 1'b1) begin n_bad++; $display("FAIL rst_outputs_zero: got %b, required 1", c_zero[13]); end
    n_cmp++;
    if (c_idle[13] !== 1'b1) begin n_bad++; $display("FAIL rst_state_idle: got %b, required 1", c_idle[13]); end
    n_cmp++;
    if (m_rwe !== 64'd0) begin n_bad++; $display("FAIL rst_no_res_we: got %h, required 0", m_rwe); end
    n_cmp++;
    if (m_done !== 64'd0) begin n_bad++; $display("FAIL rst_no_done: got %h, required 0", m_done); end
    n_cmp++;
    if ((m_busy & span(13, 30)) !== 64'd0) begin n_bad++; $display("FAIL rst_busy_after: got %h, required 0", m_busy & span(13, 30)); end
    wait_idle();
    bus.ub_base = 10'd8; bus.res_base = 10'd20; bus.weight_sel = 2'd2;
    capture(25, 0, -1, -1, -1);
    n_cmp++;
    if (m_done !== span(22, 22)) begin n_bad++; $display("FAIL rst_fresh_done: got %h, required %h", m_done, span(22, 22)); end
    n_cmp++;
    if (c_ra[18] !== 10'd20) begin n_bad++; $display("FAIL rst_fresh_res_addr: got %0d, required 20", c_ra[18]); end
  endtask

  task automatic test_default_params();
    int done_at, done_cnt, rwe_cnt, fv_cnt, first_fv, first_rwe;
    logic [9:0] first_ra;
    done_at = -1; done_cnt = 0; rwe_cnt = 0; fv_cnt = 0; first_fv = -1; first_rwe = -1; first_ra = '0;
    @(negedge clk);
    bus_d.ub_base = 10'd0; bus_d.res_base = 10'd100; bus_d.weight_sel = 2'd3;
    bus_d.start = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      bus_d.start = 1'b0;
      if (bus_d.done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (bus_d.res_we) begin
        if (first_rwe < 0) begin first_rwe = n; first_ra = bus_d.res_addr; end
        rwe_cnt++;
      end
      if (bus_d.feed_valid) begin
        if (first_fv < 0) first_fv = n;
        fv_cnt++;
      end
    end
    n_cmp++;
    if (done_at != 262) begin n_bad++; $display("FAIL dflt_done_at: got %0d, required 262", done_at); end
    n_cmp++;
    if (done_cnt != 1) begin n_bad++; $display("FAIL dflt_done_count: got %0d, required 1", done_cnt); end
    n_cmp++;
    if (rwe_cnt != 64) begin n_bad++; $display("FAIL dflt_res_we_count: got %0d, required 64", rwe_cnt); end
    n_cmp++;
    if (fv_cnt != 64) begin n_bad++; $display("FAIL dflt_feed_count: got %0d, required 64", fv_cnt); end
    n_cmp++;
    if (first_fv != 4) begin n_bad++; $display("FAIL dflt_first_feed: got %0d, required 4", first_fv); end
    n_cmp++;
    if (first_rwe != 198) begin n_bad++; $display("FAIL dflt_first_res_we: got %0d, required 198", first_rwe); end
    n_cmp++;
    if (first_ra !== 10'd100) begin n_bad++; $display("FAIL dflt_first_res_addr: got %0d, required 100", first_ra); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_pass();
    test_default_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tpu_run_sequencer.md
Name: tpu_run_sequencer

Overview:
- Registered controller that runs one complete matrix pass on the TPU datapath.
- Selects and reloads a weight tile, then streams MATRIX_SIZE activation rows from the Unified Buffer into the systolic array.
- Waits out the array and skew-register latency, then writes MATRIX_SIZE result rows into the Results SRAM.
- Replaces the free-running result counter and the separate state counter with one start/busy/done handshake.

Parameters:
- MATRIX_SIZE, 64, rows streamed per pass and rows captured per pass.
- ADDRESSSIZE, 10, Unified Buffer and Results SRAM address width.
- ADDRESSSIZE_fifo, 2, weight-store address width.
- RELOAD_CYCLES, 2, cycles we_rl is held high so the weights propagate into the PEs.
- DRAIN_CYCLES, 130, cycles from the last fed row to the first valid result row. This covers array depth, input skew and output deskew.

Ports:
- clk, in, 1, clock.
- rstn, in, 1, synchronous active-low reset.
- start, in, 1, request one pass. Sampled only in IDLE.
- ub_base, in, ADDRESSSIZE, first Unified Buffer row. Latched when start is accepted.
- res_base, in, ADDRESSSIZE, first Results SRAM row. Latched when start is accepted.
- weight_sel, in, ADDRESSSIZE_fifo, weight-store slot. Latched when start is accepted.
- busy, out, 1, high from the cycle after acceptance until done.
- done, out, 1, one-cycle pulse when the pass completes.
- ub_addr, out, ADDRESSSIZE, Unified Buffer read address.
- feed_valid, out, 1, high on the cycles ub_addr carries a valid row.
- wfifo_addr, out, ADDRESSSIZE_fifo, weight-store address.
- we_rl, out, 1, weight reload strobe to the systolic array.
- res_we, out, 1, Results SRAM write enable.
- res_addr, out, ADDRESSSIZE, Results SRAM write address.

Behaviour:
- Single clock, clk. Reset is synchronous and active-low on rstn. All outputs are registered.
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset mid-pass aborts the pass immediately on the next edge. done is not asserted, and no further res_we pulses occur.
- Cycle T0 is the edge at which start=1 is sampled in IDLE.

State sequence:
- IDLE: waits for start. T0 latches ub_base, res_base and weight_sel, then goes to WSEL.
- WSEL: 1 cycle. wfifo_addr=weight_sel gives the SRAM its read latency. Then RELOAD.
- RELOAD: we_rl=1 for exactly RELOAD_CYCLES cycles while wfifo_addr is held. Then FEED.
- FEED: exactly MATRIX_SIZE cycles, with feed_valid=1 and ub_addr = ub_base+k for k=0..MATRIX_SIZE-1. Then DRAIN.
- DRAIN: exactly DRAIN_CYCLES cycles with all strobes low. ub_addr holds its last value. Then CAPTURE.
- CAPTURE: exactly MATRIX_SIZE cycles, with res_we=1 and res_addr = res_base+k. Then DONE.
- DONE: 1 cycle with done=1 and busy=0. Then IDLE.
- Total cycles from T0 to the done edge: 2+RELOAD_CYCLES+2·MATRIX_SIZE+DRAIN_CYCLES.

Rules and boundary conditions:
- Address arithmetic is modulo 2^ADDRESSSIZE. A base near the top of the range wraps to 0 silently.
- start while busy is ignored and not queued.
- start held high through DONE launches a new pass: it is accepted in the following IDLE cycle. There is no back-to-back acceptance in DONE itself.
- Base inputs may change freely after T0.
- wfifo_addr keeps its last value outside WSEL and RELOAD.
- we_rl, feed_valid and res_we are mutually exclusive in every cycle.
- Parameters must satisfy MATRIX_SIZE ≥ 1, RELOAD_CYCLES ≥ 1 and DRAIN_CYCLES ≥ 1. A DRAIN_CYCLES value of 0 is a parameter error, flagged by an elaboration-time check.

Decomposition:
- Shared package tpu_pkg holds:
  - the state encoding enum (IDLE, WSEL, RELOAD, FEED, DRAIN, CAPTURE, DONE);
  - default MATRIX_SIZE and ADDRESSSIZE constants;
  - the DRAIN_CYCLES formula as a function of MATRIX_SIZE.
- One sub-module, tpu_phase_counter: a loadable down-counter with a terminal-count flag. It is reused across RELOAD, FEED, DRAIN and CAPTURE, so there is only one counter.
- Address generation stays in the top as base-plus-offset.

Test Plan:
- Basic pass (MATRIX_SIZE=4, RELOAD_CYCLES=2, DRAIN_CYCLES=10, start at T0 with ub_base=8, res_base=20, weight_sel=2):
  - we_rl high at T0+2..T0+3;
  - ub_addr 8,9,10,11 with feed_valid at T0+4..T0+7;
  - res_addr 20..23 with res_we at T0+18..T0+21;
  - done at T0+22.
- Wrap: ub_base=1022, MATRIX_SIZE=4 -> ub_addr 1022, 1023, 0, 1. res_base=1023 -> res_addr 1023, 0, 1, 2.
- start pulsed during FEED and CAPTURE -> ignored. Exactly one done, and total cycle count unchanged.
- start held high continuously -> a second pass is accepted the cycle after DONE. Passes are separated by exactly one IDLE cycle, and done pulses exactly once per pass.
- rstn driven low for 1 cycle in DRAIN -> next cycle all outputs are 0 and the state is IDLE. No res_we and no done follow. A fresh start then completes normally.
- Default parameters (64, 2, 130) -> done at exactly T0+262. The res_we count equals 64, and the feed_valid count equals 64.
